apb_master_bridge: RTL and testbench

//  Bridges the CPU core's single-word data-memory port (address/wdata/rdata) onto an

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_addr_decoder.sv | 36 +++
 rtl/apb_master_bridge.sv | 124 ++++++++++++
 tb/tb_apb_master_bridge.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB master types and constants.
// Optional ACCESS timeout build switch: APB_TIMEOUT_EN.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam logic [31:0] APB_TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam logic [31:0] APB_BASE_ADDR    = 32'h1000_0000;
  localparam logic [31:0] APB_SLV_SIZE     = 32'h0000_1000;

endpackage

// File: rtl/apb_addr_decoder.sv
// APB address decoder: latched PADDR to one-hot slave select,
// binary slave index and a hit flag for mapped addresses.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int          NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = APB_BASE_ADDR,
  parameter logic [31:0] SLV_SIZE  = APB_SLV_SIZE,
  parameter int          IDXW      = 2
) (
  input  logic [31:0]        paddr,
  output logic [NUM_SLV-1:0] sel,
  output logic [IDXW-1:0]    idx,
  output logic               hit
);

  logic [32:0] lo;

  // 33-bit bounds so a region ending at 4 GiB still compares correctly
  always_comb begin
    sel = '0;
    idx = '0;
    lo  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      lo = {1'b0, BASE_ADDR} + 33'(i) * {1'b0, SLV_SIZE};
      if ({1'b0, paddr} >= lo &&
          {1'b0, paddr} < lo + {1'b0, SLV_SIZE}) begin
        sel[i] = 1'b1;
        idx    = IDXW'(i);
      end
    end
  end

  assign hit = |sel;

endmodule

// File: rtl/apb_master_bridge.sv
// CPU data port to APB3 bridge; sole master, NUM_SLV slaves.
// Define APB_TIMEOUT_EN to bound ACCESS waits by TIMEOUT cycles.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = APB_BASE_ADDR,
  parameter logic [31:0] SLV_SIZE  = APB_SLV_SIZE,
  parameter int          TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    transfer,
  input  logic                    write,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic                    err,
  output logic [31:0]             PADDR,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  output logic                    PENABLE,
  output logic [NUM_SLV-1:0]      PSEL,
  input  logic [NUM_SLV*32-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]      PREADY
);

  localparam int IDXW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;

  if (NUM_SLV < 1 || NUM_SLV > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("apb_master_bridge: bad NUM_SLV or TIMEOUT");
  end

  apb_state_e          state;
  logic [NUM_SLV-1:0]  sel;
  logic [IDXW-1:0]     idx;
  logic                hit;
  logic                slv_ready;
  logic [31:0]         slv_rdata;
  logic                tmo;
  logic                done;

  apb_addr_decoder #(
    .NUM_SLV  (NUM_SLV),
    .BASE_ADDR(BASE_ADDR),
    .SLV_SIZE (SLV_SIZE),
    .IDXW     (IDXW)
  ) u_dec (
    .paddr(PADDR),
    .sel  (sel),
    .idx  (idx),
    .hit  (hit)
  );

  assign slv_ready = PREADY[idx];
  assign slv_rdata = PRDATA[{idx, 5'b0} +: 32];

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign tmo = (cnt == CW'(TIMEOUT));
`else
  assign tmo = 1'b0;
`endif

  // unmapped accesses finish on their first ACCESS cycle
  assign done    = (state == ACCESS) && (!hit || slv_ready || tmo);
  assign ready   = done;
  assign err     = done && (!hit || tmo);
  assign PENABLE = (state == ACCESS);
  assign PSEL    = (state != IDLE) ? sel : '0;

  always_comb begin
    rdata = '0;
    if (done && hit) begin
      if (tmo)
        rdata = APB_TIMEOUT_DATA;
      else if (!PWRITE)
        rdata = slv_rdata;
    end else if (done && tmo) begin
      rdata = APB_TIMEOUT_DATA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
`ifdef APB_TIMEOUT_EN
      cnt    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (transfer) begin
            PADDR  <= addr;
            PWRITE <= write;
            PWDATA <= wdata;
            state  <= SETUP;
          end
        end
        SETUP: begin
          state <= ACCESS;
`ifdef APB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        ACCESS: begin
          if (done)
            state <= IDLE;
`ifdef APB_TIMEOUT_EN
          else
            cnt <= cnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge, default 4-slave map.
// Covers both builds of APB_TIMEOUT_EN.
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         transfer = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         ready;
  logic         err;
  logic [31:0]  PADDR;
  logic         PWRITE;
  logic [31:0]  PWDATA;
  logic         PENABLE;
  logic [3:0]   PSEL;
  logic [127:0] PRDATA = '0;
  logic [3:0]   PREADY = '0;

  int nvec = 0;
  int nerr = 0;

  apb_master_bridge #(
    .NUM_SLV  (4),
    .BASE_ADDR(32'h1000_0000),
    .SLV_SIZE (32'h0000_1000),
    .TIMEOUT  (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .transfer(transfer),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .PADDR   (PADDR),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc();
    @(negedge clk);
    nvec++; if (PSEL !== 4'b0000) begin nerr++; $display("FAIL rst_psel: got %b want 0000", PSEL); end
    nvec++; if (PENABLE !== 1'b0) begin nerr++; $display("FAIL rst_penable: got %b want 0", PENABLE); end
    nvec++; if (ready !== 1'b0 || err !== 1'b0) begin nerr++; $display("FAIL rst_ready_err: got %b%b want 00", ready, err); end
    nvec++; if (rdata !== 32'h0) begin nerr++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    nvec++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0) begin
      nerr++; $display("FAIL rst_regs: got %h %h %b want 0 0 0", PADDR, PWDATA, PWRITE);
    end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_write();
    PREADY = 4'b0010;
    PRDATA = '0;
    PRDATA[63:32] = 32'hFFFF_0000;
    cyc();
    addr = 32'h1000_1004; write = 1'b1; wdata = 32'hA5A5_0001; transfer = 1'b1;
    @(negedge clk);
    nvec++; if (PSEL !== 4'b0000 || ready !== 1'b0) begin nerr++; $display("FAIL wr_c0: got psel %b ready %b want 0000 0", PSEL, ready); end
    cyc();
    transfer = 1'b0;
    @(negedge clk);
    nvec++; if (PSEL !== 4'b0010 || PENABLE !== 1'b0) begin nerr++; $display("FAIL wr_setup: got psel %b pen %b want 0010 0", PSEL, PENABLE); end
    nvec++; if (PADDR !== 32'h1000_1004 || PWDATA !== 32'hA5A5_0001 || PWRITE !== 1'b1) begin
      nerr++; $display("FAIL wr_latch: got %h %h %b want 10001004 a5a50001 1", PADDR, PWDATA, PWRITE);
    end
    nvec++; if (ready !== 1'b0) begin nerr++; $display("FAIL wr_early: got ready %b want 0", ready); end
    cyc();
    @(negedge clk);
    nvec++; if (PSEL !== 4'b0010 || PENABLE !== 1'b1) begin nerr++; $display("FAIL wr_access: got psel %b pen %b want 0010 1", PSEL, PENABLE); end
    nvec++; if (ready !== 1'b1 || err !== 1'b0 || rdata !== 32'h0) begin
      nerr++; $display("FAIL wr_done: got %b %b %h want 1 0 0", ready, err, rdata);
    end
    cyc();
    @(negedge clk);
    nvec++; if (ready !== 1'b0 || PENABLE !== 1'b0 || PSEL !== 4'b0000) begin
      nerr++; $display("FAIL wr_idle: got %b %b %b want 0 0 0000", ready, PENABLE, PSEL);
    end
    nvec++; if (PWDATA !== 32'hA5A5_0001) begin nerr++; $display("FAIL wr_hold: got %h want a5a50001", PWDATA); end
  endtask

  task automatic test_wait_read();
    PREADY = 4'b0111;
    PRDATA = {32'h1234_5678, 32'hBADB_AD02, 32'hBADB_AD01, 32'hBADB_AD00};
    for (int c = 0; c < 7; c++) begin
      cyc();
      if (c == 0) begin addr = 32'h1000_3000; write = 1'b0; transfer = 1'b1; end
      if (c == 1) transfer = 1'b0;
      if (c == 5) PREADY[3] = 1'b1;
      @(negedge clk);
      nvec++; if (ready !== (c == 5)) begin nerr++; $display("FAIL rd_wait_ready c%0d: got %b want %b", c, ready, c == 5); end
      if (c == 5) begin
        nvec++; if (rdata !== 32'h1234_5678 || err !== 1'b0) begin
          nerr++; $display("FAIL rd_wait_data: got %h err %b want 12345678 0", rdata, err);
        end
      end
    end
  endtask

  task automatic test_unmapped();
    PREADY = 4'b0000;
    PRDATA = {4{32'hCAFE_F00D}};
    for (int c = 0; c < 4; c++) begin
      cyc();
      if (c == 0) begin addr = 32'h2000_0000; write = 1'b0; transfer = 1'b1; end
      if (c == 1) transfer = 1'b0;
      @(negedge clk);
      nvec++; if (PSEL !== 4'b0000) begin nerr++; $display("FAIL um_psel c%0d: got %b want 0000", c, PSEL); end
      nvec++; if (ready !== (c == 2)) begin nerr++; $display("FAIL um_ready c%0d: got %b want %b", c, ready, c == 2); end
      if (c == 2) begin
        nvec++; if (err !== 1'b1 || rdata !== 32'h0) begin nerr++; $display("FAIL um_done: got err %b rdata %h want 1 0", err, rdata); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int nready = 0;
    PREADY = 4'b1111;
    PRDATA = {32'hDDDD_0003, 32'hBBBB_0002, 32'hCCCC_0001, 32'hAAAA_0001};
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c == 0) begin addr = 32'h1000_0008; write = 1'b0; transfer = 1'b1; end
      if (c == 3) addr = 32'h1000_2010;
      if (c == 6) transfer = 1'b0;
      @(negedge clk);
      if (ready === 1'b1) nready++;
      nvec++; if (ready !== (c == 2 || c == 5)) begin nerr++; $display("FAIL b2b_ready c%0d: got %b want %b", c, ready, c == 2 || c == 5); end
      if (c == 2) begin
        nvec++; if (rdata !== 32'hAAAA_0001) begin nerr++; $display("FAIL b2b_rd1: got %h want aaaa0001", rdata); end
      end
      if (c == 4) begin
        nvec++; if (PADDR !== 32'h1000_2010 || PSEL !== 4'b0100) begin
          nerr++; $display("FAIL b2b_addr2: got %h %b want 10002010 0100", PADDR, PSEL);
        end
      end
      if (c == 5) begin
        nvec++; if (rdata !== 32'hBBBB_0002) begin nerr++; $display("FAIL b2b_rd2: got %h want bbbb0002", rdata); end
      end
    end
    nvec++; if (nready != 2) begin nerr++; $display("FAIL b2b_count: got %0d readies want 2", nready); end
  endtask

  task automatic test_reset_abort();
    PREADY = 4'b0000;
    PRDATA = {96'h0, 32'h5555_AAAA};
    for (int c = 0; c < 3; c++) begin
      cyc();
      if (c == 0) begin addr = 32'h1000_0000; write = 1'b0; transfer = 1'b1; end
      if (c == 1) transfer = 1'b0;
      @(negedge clk);
    end
    nvec++; if (PSEL !== 4'b0001 || PENABLE !== 1'b1) begin nerr++; $display("FAIL ab_access: got %b %b want 0001 1", PSEL, PENABLE); end
    cyc();
    reset = 1'b1;
    @(negedge clk);
    nvec++; if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || ready !== 1'b0) begin
      nerr++; $display("FAIL ab_reset: got %b %b %b want 0000 0 0", PSEL, PENABLE, ready);
    end
    cyc();
    reset = 1'b0;
    @(negedge clk);
    nvec++; if (ready !== 1'b0 || PSEL !== 4'b0000) begin nerr++; $display("FAIL ab_after: got %b %b want 0 0000", ready, PSEL); end
    PREADY = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      cyc();
      if (c == 0) transfer = 1'b1;
      if (c == 1) transfer = 1'b0;
      @(negedge clk);
      nvec++; if (ready !== (c == 2)) begin nerr++; $display("FAIL ab_retry c%0d: got %b want %b", c, ready, c == 2); end
      if (c == 2) begin
        nvec++; if (rdata !== 32'h5555_AAAA) begin nerr++; $display("FAIL ab_rdata: got %h want 5555aaaa", rdata); end
      end
    end
  endtask

  task automatic test_timeout();
    int first = -1;
    int nready = 0;
    logic        f_err = 1'b0;
    logic [31:0] f_data = '0;
    PREADY = 4'b0000;
    PRDATA = {4{32'h0123_4567}};
    for (int c = 0; c < 100; c++) begin
      cyc();
      if (c == 0) begin addr = 32'h1000_1000; write = 1'b0; transfer = 1'b1; end
      if (c == 1) transfer = 1'b0;
      @(negedge clk);
      if (ready === 1'b1) begin
        nready++;
        if (first < 0) begin first = c; f_err = err; f_data = rdata; end
      end
    end
`ifdef APB_TIMEOUT_EN
    nvec++; if (first != 18 || nready != 1) begin nerr++; $display("FAIL to_cycle: got first %0d count %0d want 18 1", first, nready); end
    nvec++; if (f_err !== 1'b1 || f_data !== 32'hDEAD_BEEF) begin
      nerr++; $display("FAIL to_data: got err %b rdata %h want 1 deadbeef", f_err, f_data);
    end
`else
    nvec++; if (nready != 0) begin nerr++; $display("FAIL to_none: got %0d readies (first c%0d) want 0", nready, first); end
    nvec++; if (PENABLE !== 1'b1 || PSEL !== 4'b0010) begin nerr++; $display("FAIL to_stuck: got %b %b want 1 0010", PENABLE, PSEL); end
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait_read();
    test_unmapped();
    test_back_to_back();
    test_reset_abort();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
